// File: rtl/mole_pkg.sv
// mole_pkg: hole geometry, colours and painter states
// shared by the display controller and paint logic.
package mole_pkg;

  localparam int BLOCK_DEF = 8;
  localparam int Y0_DEF    = 33;
  localparam int X0_DEF    = 1;
  localparam int X1_DEF    = 9;
  localparam int X2_DEF    = 17;

  localparam logic [2:0] MOLE_UP   = 3'b100;
  localparam logic [2:0] MOLE_DOWN = 3'b000;

  typedef enum logic {
    IDLE = 1'b0,
    DRAW = 1'b1
  } state_t;

endpackage

// File: rtl/block_scanner.sv
// block_scanner: cx/cy raster over one BLOCK x BLOCK square.
// ports: clock, reset, start (zero), step (advance) -> cx, cy, last.
module block_scanner #(
  parameter int BLOCK = 8
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  input  logic       step,
  output logic [3:0] cx,
  output logic [3:0] cy,
  output logic       last
);

  localparam logic [3:0] LAST = 4'(BLOCK - 1);

  assign last = (cx == LAST) && (cy == LAST);

  always_ff @(posedge clock) begin
    if (reset || start) begin
      cx <= '0;
      cy <= '0;
    end else if (step) begin
      if (cx == LAST) begin
        cx <= '0;
        cy <= (cy == LAST) ? '0 : cy + 4'd1;
      end else begin
        cx <= cx + 4'd1;
      end
    end
  end

endmodule

// File: rtl/mole_painter.sv
// mole_painter: repaints changed/dirty mole holes one block at a time.
// ports: clock, reset, mole1..3 in; x, y, colour, plot, busy out.
module mole_painter
  import mole_pkg::*;
#(
  parameter int BLOCK = BLOCK_DEF,
  parameter int Y0    = Y0_DEF,
  parameter int X0    = X0_DEF,
  parameter int X1    = X1_DEF,
  parameter int X2    = X2_DEF
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       mole1,
  input  logic       mole2,
  input  logic       mole3,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       busy
);

  state_t     state;
  logic [2:0] shown;
  logic [2:0] dirty;
  logic [1:0] sel;
  logic       up;
  logic [2:0] moles;
  logic [2:0] pending;
  logic [1:0] pick;
  logic [7:0] xb;
  logic [3:0] cx;
  logic [3:0] cy;
  logic       last;
  logic       start;
  logic       step;

  assign moles   = {mole3, mole2, mole1};
  assign pending = (moles ^ shown) | dirty;
  assign start   = (state == IDLE) && (pending != 3'b000);
  assign step    = (state == DRAW);

  // lowest pending hole wins
  always_comb begin
    pick = 2'd2;
    if (pending[0])
      pick = 2'd0;
    else if (pending[1])
      pick = 2'd1;
  end

  always_comb begin
    xb = 8'(X2);
    unique case (sel)
      2'd0:    xb = 8'(X0);
      2'd1:    xb = 8'(X1);
      default: xb = 8'(X2);
    endcase
  end

  block_scanner #(
    .BLOCK(BLOCK)
  ) u_scan (
    .clock(clock),
    .reset(reset),
    .start(start),
    .step (step),
    .cx   (cx),
    .cy   (cy),
    .last (last)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      shown <= 3'b000;
      dirty <= 3'b111;
      sel   <= 2'd0;
      up    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            sel   <= pick;
            up    <= moles[pick];
            state <= DRAW;
          end
        end
        DRAW: begin
          if (last) begin
            shown[sel] <= up;
            dirty[sel] <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // pixel bus is decoded from registers only; idle drives zeros
  assign busy   = (state == DRAW);
  assign plot   = busy;
  assign x      = busy ? xb + {4'b0, cx} : 8'd0;
  assign y      = busy ? 7'(Y0) + {3'b0, cy} : 7'd0;
  assign colour = busy ? (up ? MOLE_UP : MOLE_DOWN) : 3'b000;

endmodule

// File: tb/tb_mole_painter.sv
// tb_mole_painter: directed bench for mole_painter.
// drives at negedge, samples at negedge.
module tb_mole_painter;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       mole1 = 1'b0;
  logic       mole2 = 1'b0;
  logic       mole3 = 1'b0;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       busy;

  int errors = 0;
  int checks = 0;

  // word: {busy, plot, x, y, colour}
  logic [19:0] got[$];
  logic [19:0] exp[$];
  int hx[3] = '{1, 9, 17};

  mole_painter dut (
    .clock (clock),
    .reset (reset),
    .mole1 (mole1),
    .mole2 (mole2),
    .mole3 (mole3),
    .x     (x),
    .y     (y),
    .colour(colour),
    .plot  (plot),
    .busy  (busy)
  );

  always #5 clock = ~clock;

  task automatic add_block(input int h, input logic [2:0] c);
    for (int cy = 0; cy < 8; cy++)
      for (int cx = 0; cx < 8; cx++)
        exp.push_back({1'b1, 1'b1, 8'(hx[h] + cx), 7'(33 + cy), c});
  endtask

  task automatic add_idle(input int n);
    repeat (n) exp.push_back(20'd0);
  endtask

  task automatic capture(input int n);
    got.delete();
    repeat (n) begin
      @(negedge clock);
      got.push_back({busy, plot, x, y, colour});
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    checks++;
    if (plot !== 1'b0) begin
      errors++;
      $display("FAIL reset_plot got=%b exp=0", plot);
    end
    checks++;
    if (x !== 8'd0) begin
      errors++;
      $display("FAIL reset_x got=%0d exp=0", x);
    end
    checks++;
    if (y !== 7'd0) begin
      errors++;
      $display("FAIL reset_y got=%0d exp=0", y);
    end
    checks++;
    if (colour !== 3'b000) begin
      errors++;
      $display("FAIL reset_colour got=%b exp=000", colour);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_busy got=%b exp=0", busy);
    end
  endtask

  task automatic test_clear;
    exp.delete();
    add_block(0, 3'b000);
    add_idle(1);
    add_block(1, 3'b000);
    add_idle(1);
    add_block(2, 3'b000);
    add_idle(3);
    reset = 1'b0;
    capture(exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (exp[i][18] ? (got[i] !== exp[i])
                     : (got[i][19:18] !== exp[i][19:18])) begin
        errors++;
        $display("FAIL clear[%0d] got=%h exp=%h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_mole2;
    int n;
    exp.delete();
    add_block(1, 3'b100);
    add_idle(2);
    mole2 = 1'b1;
    capture(exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (exp[i][18] ? (got[i] !== exp[i])
                     : (got[i][19:18] !== exp[i][19:18])) begin
        errors++;
        $display("FAIL mole2[%0d] got=%h exp=%h", i, got[i], exp[i]);
      end
    end
    n = 0;
    repeat (20) begin
      @(negedge clock);
      if (plot) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL mole2_settled plots=%0d exp=0", n);
    end
  endtask

  task automatic test_pulse;
    exp.delete();
    add_block(0, 3'b100);
    add_idle(1);
    add_block(0, 3'b000);
    add_idle(3);
    mole1 = 1'b1;
    fork
      begin
        repeat (10) @(negedge clock);
        mole1 = 1'b0;
      end
    join_none
    capture(exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (exp[i][18] ? (got[i] !== exp[i])
                     : (got[i][19:18] !== exp[i][19:18])) begin
        errors++;
        $display("FAIL pulse[%0d] got=%h exp=%h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_two;
    exp.delete();
    add_block(0, 3'b100);
    add_idle(1);
    add_block(2, 3'b100);
    add_idle(3);
    mole1 = 1'b1;
    mole3 = 1'b1;
    capture(exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (exp[i][18] ? (got[i] !== exp[i])
                     : (got[i][19:18] !== exp[i][19:18])) begin
        errors++;
        $display("FAIL two[%0d] got=%h exp=%h", i, got[i], exp[i]);
      end
    end
  endtask

  task automatic test_idle;
    int n;
    n = 0;
    repeat (1000) begin
      @(negedge clock);
      if (plot || busy) n++;
    end
    checks++;
    if (n !== 0) begin
      errors++;
      $display("FAIL idle_quiet active=%0d exp=0", n);
    end
  endtask

  task automatic test_reset_mid;
    exp.delete();
    add_block(1, 3'b000);
    exp = exp[0:19];
    mole2 = 1'b0;
    capture(20);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (got[i] !== exp[i]) begin
        errors++;
        $display("FAIL part[%0d] got=%h exp=%h", i, got[i], exp[i]);
      end
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (plot !== 1'b0) begin
      errors++;
      $display("FAIL abort_plot got=%b exp=0", plot);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL abort_busy got=%b exp=0", busy);
    end
    exp.delete();
    add_block(0, 3'b100);
    add_idle(1);
    add_block(1, 3'b000);
    add_idle(1);
    add_block(2, 3'b100);
    add_idle(3);
    reset = 1'b0;
    capture(exp.size());
    for (int i = 0; i < exp.size(); i++) begin
      checks++;
      if (exp[i][18] ? (got[i] !== exp[i])
                     : (got[i][19:18] !== exp[i][19:18])) begin
        errors++;
        $display("FAIL reclear[%0d] got=%h exp=%h", i, got[i], exp[i]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_clear();
    test_mole2();
    test_pulse();
    test_two();
    test_idle();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
